// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// -----------------
// Shares one RAM port between the instruction cache and the data cache.
// Only one requester is granted at a time. The granted request's address and
// data are steered straight to the RAM (nothing is latched). The granted
// requester sees its wait signal drop in the cycle the RAM reports ACCESS.
//
// Ports
//   CLK, RST               clock, synchronous active-high reset
//   iREN, iaddr            icache read request and address
//   iwait, iload           icache wait (low = data valid) and read data
//   dREN, dWEN, daddr,     dcache read/write request, address, write data
//   dstore
//   dwait, dload           dcache wait (low = access done) and read data
//   ramREN, ramWEN,        RAM enables, address and write data
//   ramaddr, ramstore
//   ramload, ramstate      RAM read data and status (FREE/BUSY/ACCESS/ERROR)
//   icnt, dcnt, errcnt     completed icache / dcache transfers, error count
//
// Configuration
//   CACHE_ARB_RR_EN        when defined, simultaneous requests in IDLE are
//                          resolved round-robin; otherwise the dcache always
//                          wins.
module cache_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic              iwait,
    output logic [DATA_W-1:0] iload,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [DATA_W-1:0] dstore,
    output logic              dwait,
    output logic [DATA_W-1:0] dload,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [DATA_W-1:0] ramstore,
    input  logic [DATA_W-1:0] ramload,
    input  logic [1:0]        ramstate,
    output logic [CNT_W-1:0]  icnt,
    output logic [CNT_W-1:0]  dcnt,
    output logic [CNT_W-1:0]  errcnt
);

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        IGNT = 2'd1,
        DGNT = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  icnt_q, icnt_d;
    logic [CNT_W-1:0]  dcnt_q, dcnt_d;
    logic [CNT_W-1:0]  errcnt_q, errcnt_d;
    logic              dReq;
    logic              pickD;

    assign dReq = dREN | dWEN;

`ifdef CACHE_ARB_RR_EN
    // preferI_q set means the icache wins the next tie; it is cleared at
    // reset so the dcache is preferred first, and after every completion or
    // error it points away from whoever was just served.
    logic preferI_q, preferI_d;
    assign pickD = dReq & (~iREN | ~preferI_q);
`else
    assign pickD = dReq;
`endif

    // Read data is a plain pass-through; consumers qualify it with wait.
    assign iload = ramload;
    assign dload = ramload;

    assign icnt   = icnt_q;
    assign dcnt   = dcnt_q;
    assign errcnt = errcnt_q;

    // Next-state and output logic. A dropped request aborts the grant at
    // once: the RAM enables follow the live request lines, so they fall in
    // the same cycle and the FSM returns to IDLE without counting anything.
    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        dcnt_d   = dcnt_q;
        errcnt_d = errcnt_q;
        iwait    = 1'b1;
        dwait    = 1'b1;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
`ifdef CACHE_ARB_RR_EN
        preferI_d = preferI_q;
`endif
        case (state_q)
            IDLE: begin
                if (pickD) begin
                    state_d = DGNT;
                end else if (iREN) begin
                    state_d = IGNT;
                end
            end
            IGNT: begin
                ramREN  = iREN;
                ramaddr = iaddr;
                if (!iREN) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    iwait   = 1'b0;
                    icnt_d  = icnt_q + 1'b1;
                    state_d = IDLE;
`ifdef CACHE_ARB_RR_EN
                    preferI_d = 1'b0;
`endif
                end else if (ramstate == RAM_ERROR) begin
                    errcnt_d = errcnt_q + 1'b1;
                    state_d  = IDLE;
`ifdef CACHE_ARB_RR_EN
                    preferI_d = 1'b0;
`endif
                end
            end
            DGNT: begin
                ramWEN   = dWEN;
                ramREN   = dREN & ~dWEN;
                ramaddr  = daddr;
                ramstore = dstore;
                if (!dReq) begin
                    state_d = IDLE;
                end else if (ramstate == RAM_ACCESS) begin
                    dwait   = 1'b0;
                    dcnt_d  = dcnt_q + 1'b1;
                    state_d = IDLE;
`ifdef CACHE_ARB_RR_EN
                    preferI_d = 1'b1;
`endif
                end else if (ramstate == RAM_ERROR) begin
                    errcnt_d = errcnt_q + 1'b1;
                    state_d  = IDLE;
`ifdef CACHE_ARB_RR_EN
                    preferI_d = 1'b1;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            icnt_q   <= '0;
            dcnt_q   <= '0;
            errcnt_q <= '0;
`ifdef CACHE_ARB_RR_EN
            preferI_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            dcnt_q   <= dcnt_d;
            errcnt_q <= errcnt_d;
`ifdef CACHE_ARB_RR_EN
            preferI_q <= preferI_d;
`endif
        end
    end

endmodule
